// File: rtl/cmp_flag_unit.sv
//==============================================================================
// Module      : cmp_flag_unit
// Description : Multi-cycle magnitude/equality comparator stage. Operands are
//               accepted on a valid/ready handshake. They are scanned one
//               CHUNK-bit slice per clock, starting at the MSB. Registered
//               eq/lt/gt flags are then presented on a second valid/ready
//               handshake. Unsigned or two's-complement mode is chosen per
//               operation.
// Options     : CMP_EARLY_EXIT_EN - when defined, the scan stops on the first
//               mismatching slice, so latency depends on the data. When it is
//               undefined, all N slices are always scanned. The flag values
//               are the same in both builds.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cmp_flag_unit #(
    parameter int BUS_SIZE = 16,
    parameter int CHUNK    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BUS_SIZE-1:0] a,
    input  logic [BUS_SIZE-1:0] b,
    input  logic                signed_cmp,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                eq,
    output logic                lt,
    output logic                gt,
    output logic                busy
);

    // Number of slices and the width of the index that walks them.
    localparam int N     = BUS_SIZE / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [IDX_W-1:0] c_IDX_TOP  = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] c_IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] c_IDX_ZERO = '0;

    // Flipping the slice MSB maps two's-complement order onto unsigned order.
    localparam logic [CHUNK-1:0] c_MSB_MASK = CHUNK'(1) << (CHUNK - 1);

`ifdef CMP_EARLY_EXIT_EN
    localparam logic c_EARLY_EXIT = 1'b1;
`else
    localparam logic c_EARLY_EXIT = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;

    // Operands and mode, captured at acceptance.
    logic [BUS_SIZE-1:0]   r_a;
    logic [BUS_SIZE-1:0]   r_b;
    logic                  r_signed;

    // Scan position and the record of the first (most significant) mismatch.
    logic [IDX_W-1:0]      r_idx;
    logic                  r_mis;
    logic                  r_mis_lt;

    // Split the captured operands into slices. Slice 0 holds the LSBs.
    logic [CHUNK-1:0]      w_a_chunk [N];
    logic [CHUNK-1:0]      w_b_chunk [N];

    generate
        for (genvar g = 0; g < N; g++) begin : g_slice
            assign w_a_chunk[g] = r_a[g*CHUNK +: CHUNK];
            assign w_b_chunk[g] = r_b[g*CHUNK +: CHUNK];
        end
    endgenerate

    logic [CHUNK-1:0]      w_sel_a;
    logic [CHUNK-1:0]      w_sel_b;
    logic                  w_flip;
    logic                  w_chunk_ne;
    logic                  w_chunk_lt;
    logic                  w_any_mis;
    logic                  w_dec_lt;
    logic                  w_scan_exit;

    // Compare the current slice and decide whether the scan ends this cycle.
    always_comb begin
        w_flip      = r_signed && (r_idx == c_IDX_TOP);
        w_sel_a     = w_a_chunk[r_idx] ^ (w_flip ? c_MSB_MASK : '0);
        w_sel_b     = w_b_chunk[r_idx] ^ (w_flip ? c_MSB_MASK : '0);
        w_chunk_ne  = (w_sel_a != w_sel_b);
        w_chunk_lt  = (w_sel_a <  w_sel_b);
        // An earlier recorded mismatch always outranks the current slice.
        w_any_mis   = r_mis || w_chunk_ne;
        w_dec_lt    = r_mis ? r_mis_lt : w_chunk_lt;
        w_scan_exit = (r_idx == c_IDX_ZERO) || (c_EARLY_EXIT && w_chunk_ne);
    end

    // Control FSM with registered handshake, status and flag outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_signed  <= 1'b0;
            r_idx     <= c_IDX_TOP;
            r_mis     <= 1'b0;
            r_mis_lt  <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
            gt        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_signed <= signed_cmp;
                        r_idx    <= c_IDX_TOP;
                        r_mis    <= 1'b0;
                        r_mis_lt <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= S_SCAN;
                    end
                end

                S_SCAN: begin
                    // Latch the first mismatch only; later slices never override it.
                    if (!r_mis && w_chunk_ne) begin
                        r_mis    <= 1'b1;
                        r_mis_lt <= w_chunk_lt;
                    end
                    if (w_scan_exit) begin
                        eq        <= !w_any_mis;
                        lt        <=  w_any_mis &&  w_dec_lt;
                        gt        <=  w_any_mis && !w_dec_lt;
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_idx <= r_idx - c_IDX_ONE;
                    end
                end

                S_DONE: begin
                    // The flags keep their values into IDLE until the next result.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cmp_flag_unit.sv
//==============================================================================
// Module      : tb_cmp_flag_unit
// Description : Self-checking bench for cmp_flag_unit. It uses directed
//               scenarios followed by randomized operations. Results are
//               checked against an arithmetic reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cmp_flag_unit;

    localparam int BUS = 16;
    localparam int CH  = 4;
    localparam int N   = BUS / CH;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [BUS-1:0] a;
    logic [BUS-1:0] b;
    logic           signed_cmp;
    logic           out_valid;
    logic           out_ready;
    logic           eq;
    logic           lt;
    logic           gt;
    logic           busy;

    int n_vec;
    int n_fail;

    cmp_flag_unit #(
        .BUS_SIZE (BUS),
        .CHUNK    (CH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .signed_cmp (signed_cmp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .eq         (eq),
        .lt         (lt),
        .gt         (gt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stop a hung run.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Reference: returns {eq, lt, gt} from plain integer comparison.
    function automatic logic [2:0] model_flags(input logic [BUS-1:0] x, input logic [BUS-1:0] y,
                                               input logic s);
        if (x == y) return 3'b100;
        if (s) return ($signed(x) < $signed(y)) ? 3'b010 : 3'b001;
        return (x < y) ? 3'b010 : 3'b001;
    endfunction

    // Reference: edges from the accepting edge until out_valid.
    function automatic int model_lat(input logic [BUS-1:0] x, input logic [BUS-1:0] y);
`ifdef CMP_EARLY_EXIT_EN
        logic [BUS-1:0] d;
        d = x ^ y;
        for (int i = 0; i < N; i++) begin
            if (((d >> ((N - 1 - i) * CH)) & BUS'((1 << CH) - 1)) != '0) return i + 1;
        end
        return N;
`else
        return N;
`endif
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic [2:0] exp);
        chk1({tag, "_eq"}, eq, exp[2]);
        chk1({tag, "_lt"}, lt, exp[1]);
        chk1({tag, "_gt"}, gt, exp[0]);
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!in_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk1("wait_in_ready", in_ready, 1'b1);
    endtask

    // One complete operation: accept, scan, hold the result, release.
    task automatic run_op(input logic [BUS-1:0] ta, input logic [BUS-1:0] tb_v,
                          input logic ts, input int hold);
        logic [2:0] ef;
        int         el;
        int         m;
        ef = model_flags(ta, tb_v, ts);
        el = model_lat(ta, tb_v);
        wait_ready();
        a          = ta;
        b          = tb_v;
        signed_cmp = ts;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        // Change the inputs after acceptance; the result must not follow them.
        in_valid   = 1'b0;
        a          = BUS'($urandom);
        b          = BUS'($urandom);
        signed_cmp = ~ts;
        chk1("busy_after_accept", busy, 1'b1);
        chk1("in_ready_after_accept", in_ready, 1'b0);
        m = 0;
        while (!out_valid && m <= N) begin
            @(posedge clk); #1;
            m++;
        end
        chkn("latency", m, el);
        chk_flags("flags", ef);
        chk1("in_ready_done", in_ready, 1'b0);
        // Back-pressure with a stray in_valid that must be ignored.
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            a        = BUS'($urandom);
            b        = BUS'($urandom);
            @(posedge clk); #1;
            chk1("hold_out_valid", out_valid, 1'b1);
            chk1("hold_in_ready", in_ready, 1'b0);
            chk_flags("hold", ef);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk1("release_out_valid", out_valid, 1'b0);
        chk1("release_in_ready", in_ready, 1'b1);
        chk1("release_busy", busy, 1'b0);
        chk_flags("retained", ef);
    endtask

    initial begin
        logic [BUS-1:0] ra;
        logic [BUS-1:0] rb;
        logic           rs;
        n_vec      = 0;
        n_fail     = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a          = '0;
        b          = '0;
        signed_cmp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk_flags("rst", 3'b000);

        // Directed scenarios.
        run_op(16'h1234, 16'h1234, 1'b0, 0);
        run_op(16'h1000, 16'h2000, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b1, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0);
        run_op(16'h0012, 16'h0013, 1'b0, 0);
        run_op(16'h7FFF, 16'h8000, 1'b1, 0);
        run_op(16'h8000, 16'h8000, 1'b1, 5);

        // Reset during SCAN discards the operation and clears the flags.
        wait_ready();
        a          = 16'h8000;
        b          = 16'h0001;
        signed_cmp = 1'b0;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk1("scanrst_in_ready", in_ready, 1'b1);
        chk1("scanrst_out_valid", out_valid, 1'b0);
        chk1("scanrst_busy", busy, 1'b0);
        chk_flags("scanrst", 3'b000);
        repeat (N + 1) @(posedge clk);
        #1;
        chk1("scanrst_no_result", out_valid, 1'b0);
        run_op(16'h0005, 16'h0003, 1'b0, 0);

        // Randomized operations with biased operand relationships.
        for (int i = 0; i < 40; i++) begin
            ra = BUS'($urandom);
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ BUS'(1 << $urandom_range(0, BUS - 1));
                2:       rb = ra ^ BUS'(16'h8000);
                default: rb = BUS'($urandom);
            endcase
            run_op(ra, rb, rs, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
